// File: rtl/skid_pipe_reg.sv
// ---------------------------------------------------------------------------
// skid_pipe_reg
//
// Pipeline-stage register with a valid/ready handshake and a two-entry skid
// buffer. The upstream ready is taken straight from a flop, so there is no
// combinational path from out_ready back to in_ready. A synchronous flush
// squashes everything held (mispredict recovery). Both payload registers
// come out of reset holding RESET_VAL.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous squash of all held entries
//   in_valid   producer has data
//   in_data    producer payload (WIDTH bits)
//   in_ready   stage can accept (registered)
//   out_valid  main entry holds valid data
//   out_data   main entry payload, straight from a register
//   out_ready  consumer accepts
//   occupancy  number of valid entries held, 0..2 (registered)
// ---------------------------------------------------------------------------
module skid_pipe_reg #(
    parameter int               WIDTH     = 33,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    // The state encoding is the pair of valid bits {skid_valid, main_valid}.
    // 2'b10 (skid without main) is illegal and is never produced.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               in_ready_q, in_ready_d;
    logic [1:0]         occupancy_q, occupancy_d;

    logic               in_fire;
    logic               out_fire;

    // State and payload registers. Reset clears the valid bits immediately
    // and preloads both payload registers with RESET_VAL. in_ready and
    // occupancy are kept as their own flops so neither output has any
    // combinational dependence on the current handshake inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= RESET_VAL;
            skid_data_q <= RESET_VAL;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Next-state logic. Payload registers hold unless a transition writes
    // them, so the data flops only toggle when a new value is captured.
    // When the skid entry drains, it moves into main to keep FIFO order.
    // Flush wins over every handshake: state goes to EMPTY and no payload
    // register is written that cycle, so a same-cycle in_fire is dropped.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        in_fire  = in_valid & in_ready_q;
        out_fire = state_q[0] & out_ready;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                end else if (in_fire) begin
                    state_d     = FULL;
                    skid_data_d = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (flush) begin
            state_d     = EMPTY;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
        end

        in_ready_d  = ~state_d[1];
        occupancy_d = {1'b0, state_d[0]} + {1'b0, state_d[1]};
    end

    // Outputs come straight from flops.
    always_comb begin
        out_valid = state_q[0];
        out_data  = main_data_q;
        in_ready  = in_ready_q;
        occupancy = occupancy_q;
    end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_skid_pipe_reg
//
// Self-checking bench for skid_pipe_reg. A directed vector table covers
// streaming, back-pressure, ignored input while full and flush. A
// hand-written sequence checks that reset acts without a clock edge. A
// random soak then runs against a queue-based reference model of a
// two-deep FIFO stage.
// ---------------------------------------------------------------------------
module tb_skid_pipe_reg;

    localparam int               WIDTH     = 33;
    localparam logic [WIDTH-1:0] RESET_VAL = 33'h0_DEAD_BEEF;
    localparam int               NUM_VEC   = 18;
    localparam int               SOAK      = 10000;

    typedef struct {
        logic             in_valid;
        logic [WIDTH-1:0] in_data;
        logic             out_ready;
        logic             flush;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic             exp_ready;
        logic [1:0]       exp_occ;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;

    int vectors;
    int miscompares;

    vec_t             vecs [NUM_VEC];
    logic [WIDTH-1:0] model_q [$];

    skid_pipe_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] d,
                                 input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected values; out_data only
    // when the caller says it is defined.
    task automatic checkOutput(input string tag, input int idx,
                               input logic ev, input logic [WIDTH-1:0] ed,
                               input logic chk_data, input logic er,
                               input logic [1:0] eo);
        vectors++;
        if (out_valid !== ev) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d] out_valid: got %b expected %b", tag, idx, out_valid, ev);
        end
        if (chk_data) begin
            vectors++;
            if (out_data !== ed) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d] out_data: got %h expected %h", tag, idx, out_data, ed);
            end
        end
        vectors++;
        if (in_ready !== er) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d] in_ready: got %b expected %b", tag, idx, in_ready, er);
        end
        vectors++;
        if (occupancy !== eo) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d] occupancy: got %0d expected %0d", tag, idx, occupancy, eo);
        end
        vectors++;
        if (in_ready !== (occupancy != 2'd2) || (occupancy == 2'd0 && out_valid)) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d] invariant: in_ready=%b occupancy=%0d out_valid=%b", tag, idx, in_ready, occupancy, out_valid);
        end
    endtask

    // Main test sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;

        // Directed table: inputs for one cycle, outputs seen after the edge.
        //             iv    in_data         ordy  fl    ev    exp_data        er    occ
        vecs[0]  = '{1'b1, 33'h0_0000_0001, 1'b1, 1'b0, 1'b1, 33'h0_0000_0001, 1'b1, 2'd1};
        vecs[1]  = '{1'b1, 33'h0_0000_0002, 1'b1, 1'b0, 1'b1, 33'h0_0000_0002, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 33'h0_0000_0003, 1'b1, 1'b0, 1'b1, 33'h0_0000_0003, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 33'h0_0000_0000, 1'b1, 1'b0, 1'b0, 33'h0_0000_0003, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 33'h0_AAAA_AAAA, 1'b0, 1'b0, 1'b1, 33'h0_AAAA_AAAA, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 33'h1_5555_5555, 1'b0, 1'b0, 1'b1, 33'h0_AAAA_AAAA, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 33'h1_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 33'h0_AAAA_AAAA, 1'b0, 2'd2};
        vecs[7]  = '{1'b1, 33'h1_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 33'h1_5555_5555, 1'b1, 2'd1};
        vecs[8]  = '{1'b1, 33'h1_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 33'h1_5555_5555, 1'b0, 2'd2};
        vecs[9]  = '{1'b0, 33'h0_0000_0000, 1'b1, 1'b0, 1'b1, 33'h1_FFFF_FFFF, 1'b1, 2'd1};
        vecs[10] = '{1'b0, 33'h0_0000_0000, 1'b1, 1'b0, 1'b0, 33'h1_FFFF_FFFF, 1'b1, 2'd0};
        vecs[11] = '{1'b1, 33'h0_1234_5678, 1'b0, 1'b0, 1'b1, 33'h0_1234_5678, 1'b1, 2'd1};
        vecs[12] = '{1'b1, 33'h0_8765_4321, 1'b0, 1'b0, 1'b1, 33'h0_1234_5678, 1'b0, 2'd2};
        vecs[13] = '{1'b1, 33'h0_CAFE_F00D, 1'b0, 1'b1, 1'b0, 33'h0_1234_5678, 1'b1, 2'd0};
        vecs[14] = '{1'b0, 33'h0_0000_0000, 1'b1, 1'b0, 1'b0, 33'h0_1234_5678, 1'b1, 2'd0};
        vecs[15] = '{1'b1, 33'h0_0000_0011, 1'b1, 1'b0, 1'b1, 33'h0_0000_0011, 1'b1, 2'd1};
        vecs[16] = '{1'b1, 33'h0_0000_0022, 1'b1, 1'b1, 1'b0, 33'h0_0000_0011, 1'b1, 2'd0};
        vecs[17] = '{1'b0, 33'h0_0000_0000, 1'b0, 1'b0, 1'b0, 33'h0_0000_0011, 1'b1, 2'd0};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #22;
        checkOutput("reset", 0, 1'b0, RESET_VAL, 1'b1, 1'b1, 2'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].flush);
            checkOutput("vec", i, vecs[i].exp_valid, vecs[i].exp_data, 1'b1,
                        vecs[i].exp_ready, vecs[i].exp_occ);
        end

        // Fill the stage, then assert reset between clock edges and look
        // at the outputs before any further edge arrives.
        applyStimulus(1'b1, 33'h0_0000_0ABC, 1'b0, 1'b0);
        applyStimulus(1'b1, 33'h0_0000_0DEF, 1'b0, 1'b0);
        checkOutput("prefill", 0, 1'b1, 33'h0_0000_0ABC, 1'b1, 1'b0, 2'd2);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 0, 1'b0, RESET_VAL, 1'b1, 1'b1, 2'd0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset", 0, 1'b0, RESET_VAL, 1'b1, 1'b1, 2'd0);

        // Random soak against a two-deep FIFO model. The model decides
        // acceptance from how many entries it holds before the edge.
        model_q.delete();
        for (int c = 0; c < SOAK; c++) begin
            logic             iv;
            logic             ordy;
            logic             fl;
            logic [WIDTH-1:0] d;
            logic             acc;
            logic             pop;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 40) == 0);
            d    = {1'($urandom), 32'($urandom)};

            acc = iv && (model_q.size() < 2);
            pop = ordy && (model_q.size() > 0);
            if (fl) begin
                model_q.delete();
            end else begin
                if (pop) void'(model_q.pop_front());
                if (acc) model_q.push_back(d);
            end

            applyStimulus(iv, d, ordy, fl);
            checkOutput("soak", c, model_q.size() > 0,
                        (model_q.size() > 0) ? model_q[0] : '0,
                        model_q.size() > 0, model_q.size() < 2,
                        2'(model_q.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
